nand_op_sequencer: RTL and testbench

- Upstream stage of nand_flash_controller: converts one high-level flash operation (page read, page program, block erase, device reset) into the controller's cpu_if_* access sequence.
- Polls status with command 0x70 until the device is ready, then reports pass/fail/timeout.
- Sits between the host register block and the controller, which it drives one access at a time.

---
 rtl/nand_op_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 tb/tb_nand_op_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nand_op_sequencer.sv
// Turns one host flash operation into a sequence of controller accesses,
// then polls NAND status (0x70) until ready and reports pass/fail/timeout.
module nand_op_sequencer #(
    parameter int COL_BYTES  = 2,
    parameter int ROW_BYTES  = 2,
    parameter int LEN_WIDTH  = 11,
    parameter int POLL_GAP   = 16,
    parameter int POLL_LIMIT = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   op_valid,
    output logic                   op_ready,
    input  logic [1:0]             op_code,
    input  logic [8*ROW_BYTES-1:0] op_row,
    input  logic [8*COL_BYTES-1:0] op_col,
    input  logic [LEN_WIDTH-1:0]   op_len_m1,
    input  logic                   op_wp,
    output logic                   op_done,
    output logic                   op_error,
    output logic                   op_timeout,
    output logic [7:0]             op_status,
    output logic [15:0]            cpu_if_command,
    output logic                   cpu_if_command_valid,
    output logic [31:0]            cpu_if_address,
    output logic [3:0]             cpu_if_address_bytes,
    output logic [31:0]            cpu_if_data_bytes,
    output logic                   cpu_if_data_rw,
    output logic                   cpu_if_data_wp,
    output logic                   cpu_if_access_request,
    input  logic                   cpu_if_access_ready,
    input  logic                   cpu_if_access_complete,
    input  logic                   snoop_wr,
    input  logic [31:0]            snoop_data
);

    localparam int ROW_W = 8 * ROW_BYTES;
    localparam int COL_W = 8 * COL_BYTES;
    localparam int AB    = COL_BYTES + ROW_BYTES;
    localparam int PC_W  = $clog2(POLL_LIMIT + 1);
    localparam int GC_W  = $clog2(POLL_GAP + 1);

    localparam logic [1:0] OP_READ  = 2'd0;
    localparam logic [1:0] OP_PROG  = 2'd1;
    localparam logic [1:0] OP_ERASE = 2'd2;
    localparam logic [1:0] OP_RESET = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_POLL_ISSUE,
        S_POLL_WAIT,
        S_POLL_GAP,
        S_FINISH
    } state_t;

    state_t               state_q;
    logic                 step_q;
    logic [1:0]           code_q;
    logic [ROW_W-1:0]     row_q;
    logic [COL_W-1:0]     col_q;
    logic [LEN_WIDTH-1:0] len_q;
    logic [PC_W-1:0]      poll_cnt_q;
    logic [GC_W-1:0]      gap_cnt_q;
    logic                 cap_q;
    logic                 ready_q;
    logic                 done_q;
    logic                 err_q;
    logic                 tmo_q;
    logic [7:0]           status_q;
    logic [15:0]          cmd_q;
    logic                 cmdv_q;
    logic [31:0]          addr_q;
    logic [3:0]           ab_q;
    logic [31:0]          db_q;
    logic                 rw_q;
    logic                 wp_q;
    logic                 req_q;

    logic [1:0]           code_s;
    logic [ROW_W-1:0]     row_s;
    logic [COL_W-1:0]     col_s;
    logic [LEN_WIDTH-1:0] len_s;
    logic                 step_s;
    logic [15:0]          a_cmd;
    logic                 a_cmdv;
    logic [31:0]          a_addr;
    logic [3:0]           a_ab;
    logic [31:0]          a_db;
    logic                 a_rw;
    logic                 a_wp;
    logic [7:0]           status_now;
    logic                 prog_err;
    logic                 unused_snoop;

    assign unused_snoop = ^snoop_data[31:8];

    // Fields of the next data-phase access; in IDLE they come straight
    // from the op inputs so the access can be loaded on the accept edge.
    always_comb begin
        code_s = (state_q == S_IDLE) ? op_code : code_q;
        row_s  = (state_q == S_IDLE) ? op_row : row_q;
        col_s  = (state_q == S_IDLE) ? op_col : col_q;
        len_s  = (state_q == S_IDLE) ? op_len_m1 : len_q;
        step_s = (state_q == S_WAIT);
        a_cmd  = 16'h0000;
        a_cmdv = 1'b0;
        a_addr = 32'h0;
        a_ab   = 4'd0;
        a_db   = 32'h0;
        a_rw   = 1'b0;
        a_wp   = 1'b1;
        unique case (code_s)
            OP_READ: begin
                a_cmd  = 16'h3000;
                a_cmdv = 1'b1;
                a_addr = 32'({row_s, col_s});
                a_ab   = 4'(AB - 1);
                a_db   = 32'(len_s);
                a_rw   = 1'b1;
            end
            OP_PROG: begin
                a_wp = 1'b0;
                if (!step_s) begin
                    a_cmd  = 16'h0080;
                    a_addr = 32'({row_s, col_s});
                    a_ab   = 4'(AB - 1);
                    a_db   = 32'(len_s);
                end else begin
                    a_cmd = 16'h0010;
                end
            end
            OP_ERASE: begin
                a_cmd  = 16'hD060;
                a_cmdv = 1'b1;
                a_addr = 32'(row_s);
                a_ab   = 4'(ROW_BYTES - 1);
                a_wp   = 1'b0;
            end
            default: begin
                a_cmd = 16'h00FF;
            end
        endcase
    end

    // A snoop write coinciding with completion must still be judged.
    assign status_now = (snoop_wr && !cap_q) ? snoop_data[7:0] : status_q;
    assign prog_err   = (code_q != OP_RESET) && status_now[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            step_q     <= 1'b0;
            code_q     <= 2'd0;
            row_q      <= '0;
            col_q      <= '0;
            len_q      <= '0;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            cap_q      <= 1'b0;
            ready_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            status_q   <= 8'h00;
            cmd_q      <= 16'h0000;
            cmdv_q     <= 1'b0;
            addr_q     <= 32'h0;
            ab_q       <= 4'd0;
            db_q       <= 32'h0;
            rw_q       <= 1'b0;
            wp_q       <= 1'b1;
            req_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (op_valid && ready_q) begin
                        ready_q <= 1'b0;
                        code_q  <= op_code;
                        row_q   <= op_row;
                        col_q   <= op_col;
                        len_q   <= op_len_m1;
                        step_q  <= 1'b0;
                        if (op_wp && (op_code == OP_PROG ||
                                      op_code == OP_ERASE)) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            tmo_q   <= 1'b0;
                            wp_q    <= 1'b1;
                        end else begin
                            state_q <= S_ISSUE;
                            req_q   <= 1'b1;
                            cmd_q   <= a_cmd;
                            cmdv_q  <= a_cmdv;
                            addr_q  <= a_addr;
                            ab_q    <= a_ab;
                            db_q    <= a_db;
                            rw_q    <= a_rw;
                            wp_q    <= a_wp;
                        end
                    end
                end
                S_ISSUE: begin
                    if (cpu_if_access_ready) begin
                        req_q   <= 1'b0;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (cpu_if_access_complete) begin
                        if (code_q == OP_READ) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            err_q   <= 1'b0;
                            tmo_q   <= 1'b0;
                            wp_q    <= 1'b1;
                        end else if (code_q == OP_PROG && !step_q) begin
                            step_q  <= 1'b1;
                            state_q <= S_ISSUE;
                            req_q   <= 1'b1;
                            cmd_q   <= a_cmd;
                            cmdv_q  <= a_cmdv;
                            addr_q  <= a_addr;
                            ab_q    <= a_ab;
                            db_q    <= a_db;
                            rw_q    <= a_rw;
                            wp_q    <= a_wp;
                        end else begin
                            state_q    <= S_POLL_ISSUE;
                            poll_cnt_q <= '0;
                            req_q      <= 1'b1;
                            cmd_q      <= 16'h0070;
                            cmdv_q     <= 1'b0;
                            addr_q     <= 32'h0;
                            ab_q       <= 4'd0;
                            db_q       <= 32'd3;
                            rw_q       <= 1'b1;
                        end
                    end
                end
                S_POLL_ISSUE: begin
                    if (cpu_if_access_ready) begin
                        req_q   <= 1'b0;
                        cap_q   <= 1'b0;
                        state_q <= S_POLL_WAIT;
                    end
                end
                S_POLL_WAIT: begin
                    if (snoop_wr && !cap_q) begin
                        cap_q    <= 1'b1;
                        status_q <= snoop_data[7:0];
                    end
                    if (cpu_if_access_complete) begin
                        if (status_now[6]) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            err_q   <= prog_err;
                            tmo_q   <= 1'b0;
                            wp_q    <= 1'b1;
                        end else if (poll_cnt_q + 1'b1 ==
                                     PC_W'(POLL_LIMIT)) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                            tmo_q   <= 1'b1;
                            wp_q    <= 1'b1;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 1'b1;
                            gap_cnt_q  <= '0;
                            state_q    <= S_POLL_GAP;
                        end
                    end
                end
                S_POLL_GAP: begin
                    if (gap_cnt_q == GC_W'(POLL_GAP - 1)) begin
                        state_q <= S_POLL_ISSUE;
                        req_q   <= 1'b1;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign op_ready              = ready_q;
    assign op_done               = done_q;
    assign op_error              = err_q;
    assign op_timeout            = tmo_q;
    assign op_status             = status_q;
    assign cpu_if_command        = cmd_q;
    assign cpu_if_command_valid  = cmdv_q;
    assign cpu_if_address        = addr_q;
    assign cpu_if_address_bytes  = ab_q;
    assign cpu_if_data_bytes     = db_q;
    assign cpu_if_data_rw        = rw_q;
    assign cpu_if_data_wp        = wp_q;
    assign cpu_if_access_request = req_q;

endmodule

// File: tb/tb_nand_op_sequencer.sv
// Bench for nand_op_sequencer: behavioural controller model plus
// scoreboards of expected accesses and expected completions.
module tb_nand_op_sequencer;

    localparam int COL_BYTES  = 2;
    localparam int ROW_BYTES  = 2;
    localparam int LEN_WIDTH  = 11;
    localparam int POLL_GAP   = 16;
    localparam int POLL_LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [1:0]  op_code = 2'd0;
    logic [15:0] op_row = 16'h0;
    logic [15:0] op_col = 16'h0;
    logic [10:0] op_len_m1 = 11'h0;
    logic        op_wp = 1'b0;
    logic        op_done;
    logic        op_error;
    logic        op_timeout;
    logic [7:0]  op_status;
    logic [15:0] cmd;
    logic        cmdv;
    logic [31:0] addr;
    logic [3:0]  ab;
    logic [31:0] db;
    logic        rw;
    logic        wp;
    logic        req;
    logic        acc_ready = 1'b1;
    logic        acc_cmp = 1'b0;
    logic        snp_wr = 1'b0;
    logic [31:0] snp_data = 32'h0;

    always #5 clk = ~clk;

    nand_op_sequencer #(
        .COL_BYTES (COL_BYTES),
        .ROW_BYTES (ROW_BYTES),
        .LEN_WIDTH (LEN_WIDTH),
        .POLL_GAP  (POLL_GAP),
        .POLL_LIMIT(POLL_LIMIT)
    ) dut (
        .clk                   (clk),
        .reset                 (reset),
        .op_valid              (op_valid),
        .op_ready              (op_ready),
        .op_code               (op_code),
        .op_row                (op_row),
        .op_col                (op_col),
        .op_len_m1             (op_len_m1),
        .op_wp                 (op_wp),
        .op_done               (op_done),
        .op_error              (op_error),
        .op_timeout            (op_timeout),
        .op_status             (op_status),
        .cpu_if_command        (cmd),
        .cpu_if_command_valid  (cmdv),
        .cpu_if_address        (addr),
        .cpu_if_address_bytes  (ab),
        .cpu_if_data_bytes     (db),
        .cpu_if_data_rw        (rw),
        .cpu_if_data_wp        (wp),
        .cpu_if_access_request (req),
        .cpu_if_access_ready   (acc_ready),
        .cpu_if_access_complete(acc_cmp),
        .snoop_wr              (snp_wr),
        .snoop_data            (snp_data)
    );

    typedef struct packed {
        logic [15:0] cmd;
        logic        cmdv;
        logic [31:0] addr;
        logic [3:0]  ab;
        logic [31:0] db;
        logic        rw;
        logic        wp;
    } acc_t;

    typedef struct packed {
        logic       err;
        logic       tmo;
        logic [7:0] st;
    } done_t;

    acc_t       exp_acc[$];
    done_t      exp_done[$];
    logic [7:0] stat_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int cmp_cyc = 0;
    int n_done = 0;
    int n_acc_done = 0;
    logic last_poll = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push_acc(input logic [15:0] c, input logic cv,
                            input logic [31:0] a, input logic [3:0] b,
                            input logic [31:0] d, input logic r,
                            input logic w);
        acc_t e;
        e.cmd  = c;
        e.cmdv = cv;
        e.addr = a;
        e.ab   = b;
        e.db   = d;
        e.rw   = r;
        e.wp   = w;
        exp_acc.push_back(e);
    endtask

    task automatic push_poll(input logic w, input int n);
        for (int i = 0; i < n; i++)
            push_acc(16'h0070, 1'b0, 32'h0, 4'd0, 32'd3, 1'b1, w);
    endtask

    task automatic push_done(input logic e, input logic t,
                             input logic [7:0] s);
        done_t d;
        d.err = e;
        d.tmo = t;
        d.st  = s;
        exp_done.push_back(d);
    endtask

    // Controller model: accept, stall, snoop status on polls, complete.
    initial begin : model
        acc_t       e;
        logic       poll;
        logic [7:0] s;
        forever begin
            @(negedge clk);
            if (!reset && req && acc_ready) begin
                poll = (cmd[7:0] == 8'h70);
                chk("acc_pending", 32'(exp_acc.size() > 0), 1);
                if (exp_acc.size() > 0) begin
                    e = exp_acc.pop_front();
                    chk("acc_cmd", cmd, e.cmd);
                    chk("acc_cmdv", cmdv, e.cmdv);
                    if (e.ab != 0) chk("acc_addr", addr, e.addr);
                    chk("acc_abytes", ab, e.ab);
                    chk("acc_dbytes", db, e.db);
                    if (e.db != 0) chk("acc_rw", rw, e.rw);
                    chk("acc_wp", wp, e.wp);
                end
                if (poll && last_poll)
                    chk("poll_gap", 32'(cyc - cmp_cyc >= POLL_GAP), 1);
                @(posedge clk);
                #1 acc_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                if (poll) begin
                    s = (stat_q.size() > 0) ? stat_q.pop_front() : 8'h00;
                    snp_wr   = 1'b1;
                    snp_data = {24'hA5A5A5, s};
                    @(posedge clk);
                    #1 snp_data = {24'h5A5A5A, ~s | 8'h40};
                    @(posedge clk);
                    #1 snp_wr = 1'b0;
                end
                acc_cmp = 1'b1;
                @(posedge clk);
                #1 acc_cmp = 1'b0;
                acc_ready  = 1'b1;
                cmp_cyc    = cyc;
                last_poll  = poll;
                n_acc_done++;
            end
        end
    end

    initial begin : done_mon
        done_t d;
        forever begin
            @(negedge clk);
            if (!reset && op_done) begin
                n_done++;
                chk("done_pending", 32'(exp_done.size() > 0), 1);
                if (exp_done.size() > 0) begin
                    d = exp_done.pop_front();
                    chk("done_error", op_error, d.err);
                    chk("done_timeout", op_timeout, d.tmo);
                    chk("done_status", op_status, d.st);
                    chk("done_wp", wp, 1);
                end
                @(negedge clk);
                chk("done_pulse", op_done, 0);
            end
        end
    end

    task automatic do_op(input logic [1:0] c, input logic [15:0] r,
                         input logic [15:0] col, input logic [10:0] l,
                         input logic w);
        int t;
        t = 0;
        @(negedge clk);
        op_code   = c;
        op_row    = r;
        op_col    = col;
        op_len_m1 = l;
        op_wp     = w;
        op_valid  = 1'b1;
        while (!op_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("accept_ready", op_ready, 1);
        @(posedge clk);
        #1 op_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int t;
        t = 0;
        while (n_done < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("done_count", n_done, target);
    endtask

    initial begin : main
        int base;
        int t;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ready", op_ready, 0);
        chk("rst_req", req, 0);
        chk("rst_wp", wp, 1);
        chk("rst_done", op_done, 0);
        chk("rst_status", op_status, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_dbytes", db, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        push_acc(16'h3000, 1, 32'h0012_0000, 4'd3, 32'd2047, 1, 1);
        push_done(0, 0, 8'h00);
        do_op(2'd0, 16'h0012, 16'h0000, 11'd2047, 1'b0);
        wait_done(1);

        stat_q = '{8'h80, 8'h80, 8'hE0};
        push_acc(16'h0080, 0, 32'h0040_0000, 4'd3, 32'd7, 0, 0);
        push_acc(16'h0010, 0, 32'h0, 4'd0, 32'd0, 0, 0);
        push_poll(1'b0, 3);
        push_done(0, 0, 8'hE0);
        do_op(2'd1, 16'h0040, 16'h0000, 11'd7, 1'b0);
        wait_done(2);

        stat_q = '{8'hE1};
        push_acc(16'hD060, 1, 32'h0000_0100, 4'd1, 32'd0, 0, 0);
        push_poll(1'b0, 1);
        push_done(1, 0, 8'hE1);
        do_op(2'd2, 16'h0100, 16'h0000, 11'd0, 1'b0);
        wait_done(3);

        push_done(1, 0, 8'hE1);
        do_op(2'd1, 16'h0055, 16'h0000, 11'd15, 1'b1);
        @(negedge clk);
        chk("wp_done_latency", op_done, 1);
        wait_done(4);

        push_acc(16'h00FF, 0, 32'h0, 4'd0, 32'd0, 0, 1);
        push_poll(1'b1, POLL_LIMIT);
        push_done(1, 1, 8'h00);
        do_op(2'd3, 16'h0000, 16'h0000, 11'd0, 1'b0);
        wait_done(5);

        stat_q = '{8'h00};
        base = n_acc_done;
        push_acc(16'hD060, 1, 32'h0000_0200, 4'd1, 32'd0, 0, 0);
        push_poll(1'b0, 1);
        do_op(2'd2, 16'h0200, 16'h0000, 11'd0, 1'b0);
        t = 0;
        while (n_acc_done < base + 2 && t < 500) begin
            @(negedge clk);
            t++;
        end
        chk("erase_polled", n_acc_done, base + 2);
        repeat (4) @(negedge clk);
        chk("gap_wp_low", wp, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_req", req, 0);
        chk("mid_rst_wp", wp, 1);
        chk("mid_rst_done", op_done, 0);
        chk("mid_rst_ready", op_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", op_ready, 1);
        chk("post_rst_status", op_status, 0);
        repeat (30) @(negedge clk);
        chk("abandoned_no_done", n_done, 5);

        push_acc(16'h3000, 1, 32'h0345_0010, 4'd3, 32'd0, 1, 1);
        push_done(0, 0, 8'h00);
        do_op(2'd0, 16'h0345, 16'h0010, 11'd0, 1'b0);
        wait_done(6);

        repeat (10) @(negedge clk);
        chk("acc_left", exp_acc.size(), 0);
        chk("done_left", exp_done.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
